id_inst_queue: RTL and testbench



---
 rtl/id_inst_queue.sv | 107 ++++++++++
 tb/tb_id_inst_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/id_inst_queue.sv
// Decode-stage input queue: DEPTH-entry circular buffer of {inst, pc}.
// Optional perf counters enabled by defining ID_QUEUE_PERF_EN.
module id_inst_queue #(
  parameter int          DATA_W   = 64,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h00000033,
  parameter int          CNT_W    = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fs_to_ds_valid,
  input  logic [DATA_W-1:0] if_id_bus_in,
  output logic              ds_allowin,
  input  logic              br_jmp_flag,
  input  logic              stall_flag,
  input  logic              es_allowin,
  output logic              ds_to_es_valid,
  output logic [DATA_W-1:0] id_bus_out,
`ifdef ID_QUEUE_PERF_EN
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_stall_cnt,
`endif
  output logic [CNT_W-1:0]  q_count,
  output logic              q_empty,
  output logic              q_full
);

  localparam int PC_W  = DATA_W - 32;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_head;

  // Wrap at DEPTH-1 explicitly so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign q_count        = r_count;
  assign q_empty        = (r_count == '0);
  assign q_full         = (r_count == CNT_W'(DEPTH));
  assign ds_to_es_valid = !q_empty && !stall_flag && !br_jmp_flag;
  assign w_pop          = ds_to_es_valid && es_allowin;
  assign ds_allowin     = !q_full || w_pop;
  assign w_push         = fs_to_ds_valid && ds_allowin && !br_jmp_flag;
  assign w_head         = r_mem[r_rd_ptr];

  // Head presentation with NOP substitution on flush or empty.
  always_comb begin
    id_bus_out = w_head;
    if (br_jmp_flag)
      id_bus_out = {NOP_INST, w_head[PC_W-1:0]};
    else if (q_empty)
      id_bus_out = {NOP_INST, {PC_W{1'b0}}};
  end

  // Entry storage; a push writes at the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= if_id_bus_in;
    end
  end

  // Pointers and occupancy; a flush empties the queue outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (br_jmp_flag) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

`ifdef ID_QUEUE_PERF_EN
  // Count flushes and stalls that hit a non-empty queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_flush_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (br_jmp_flag && !q_empty)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (stall_flag && !q_empty && !br_jmp_flag)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_inst_queue.sv
// Directed bench for id_inst_queue (DEPTH=4, DATA_W=64).
// Hand-computed expectations per cycle.
module tb_id_inst_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fs_to_ds_valid;
  logic [63:0] if_id_bus_in;
  logic        ds_allowin;
  logic        br_jmp_flag;
  logic        stall_flag;
  logic        es_allowin;
  logic        ds_to_es_valid;
  logic [63:0] id_bus_out;
  logic [2:0]  q_count;
  logic        q_empty;
  logic        q_full;
`ifdef ID_QUEUE_PERF_EN
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  localparam logic [63:0] NOP0 = {32'h00000033, 32'h0};

  id_inst_queue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fs_to_ds_valid (fs_to_ds_valid),
    .if_id_bus_in   (if_id_bus_in),
    .ds_allowin     (ds_allowin),
    .br_jmp_flag    (br_jmp_flag),
    .stall_flag     (stall_flag),
    .es_allowin     (es_allowin),
    .ds_to_es_valid (ds_to_es_valid),
    .id_bus_out     (id_bus_out),
`ifdef ID_QUEUE_PERF_EN
    .perf_flush_cnt (perf_flush_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .q_count        (q_count),
    .q_empty        (q_empty),
    .q_full         (q_full)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ent(input logic [31:0] pc);
    return {32'hA000_0000 | pc, pc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      assert (q_count <= 3'd4);
      assert (!(q_empty && ds_to_es_valid && es_allowin));
    end
  end

  initial begin
    rst_n          = 1'b0;
    fs_to_ds_valid = 1'b0;
    if_id_bus_in   = '0;
    br_jmp_flag    = 1'b0;
    stall_flag     = 1'b0;
    es_allowin     = 1'b1;
    cyc(); cyc();
    chk("rst_cnt",   64'(q_count), 64'd0);
    chk("rst_empty", 64'(q_empty), 64'd1);
    chk("rst_full",  64'(q_full), 64'd0);
    chk("rst_alw",   64'(ds_allowin), 64'd1);
    chk("rst_vld",   64'(ds_to_es_valid), 64'd0);
    chk("rst_bus",   id_bus_out, NOP0);
    rst_n = 1'b1;
    cyc();

    // streaming: each entry visible one cycle after push
    fs_to_ds_valid = 1'b1; if_id_bus_in = ent(32'h00); #1;
    chk("s0_cnt", 64'(q_count), 64'd0);
    chk("s0_bus", id_bus_out, NOP0);
    cyc();
    if_id_bus_in = ent(32'h04); #1;
    chk("s1_bus", id_bus_out, ent(32'h00));
    chk("s1_vld", 64'(ds_to_es_valid), 64'd1);
    chk("s1_cnt", 64'(q_count), 64'd1);
    cyc();
    if_id_bus_in = ent(32'h08); #1;
    chk("s2_bus", id_bus_out, ent(32'h04));
    chk("s2_cnt", 64'(q_count), 64'd1);
    cyc();
    fs_to_ds_valid = 1'b0; #1;
    chk("s3_bus", id_bus_out, ent(32'h08));
    chk("s3_cnt", 64'(q_count), 64'd1);
    cyc();
    chk("s4_empty", 64'(q_empty), 64'd1);

    // fill with execute blocked; fifth entry is held
    es_allowin = 1'b0;
    fs_to_ds_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_id_bus_in = ent(32'h10 + 32'(4*i));
      cyc();
    end
    if_id_bus_in = ent(32'h20); #1;
    chk("f_full", 64'(q_full), 64'd1);
    chk("f_alw",  64'(ds_allowin), 64'd0);
    chk("f_cnt",  64'(q_count), 64'd4);
    chk("f_bus",  id_bus_out, ent(32'h10));
    cyc();
    chk("f_hold_cnt", 64'(q_count), 64'd4);
    chk("f_hold_bus", id_bus_out, ent(32'h10));

    // full replacement: pop+push each cycle, across pointer wrap
    es_allowin = 1'b1; #1;
    chk("r0_alw", 64'(ds_allowin), 64'd1);
    chk("r0_bus", id_bus_out, ent(32'h10));
    cyc();
    if_id_bus_in = ent(32'h24); #1;
    chk("r1_bus", id_bus_out, ent(32'h14));
    chk("r1_cnt", 64'(q_count), 64'd4);
    cyc();
    if_id_bus_in = ent(32'h28); #1;
    chk("r2_bus", id_bus_out, ent(32'h18));
    chk("r2_cnt", 64'(q_count), 64'd4);
    cyc();
    fs_to_ds_valid = 1'b0; #1;
    chk("r3_bus", id_bus_out, ent(32'h1C));
    chk("r3_cnt", 64'(q_count), 64'd4);
    cyc();
    es_allowin = 1'b0; #1;
    chk("r4_cnt", 64'(q_count), 64'd3);
    chk("r4_bus", id_bus_out, ent(32'h20));

    // flush with a concurrent push
    br_jmp_flag = 1'b1;
    fs_to_ds_valid = 1'b1; if_id_bus_in = ent(32'h40); #1;
    chk("fl_bus", id_bus_out, {32'h00000033, 32'h20});
    chk("fl_vld", 64'(ds_to_es_valid), 64'd0);
    cyc();
    br_jmp_flag = 1'b0; fs_to_ds_valid = 1'b0; #1;
    chk("fl_cnt",   64'(q_count), 64'd0);
    chk("fl_empty", 64'(q_empty), 64'd1);
    chk("fl_nop",   id_bus_out, NOP0);
    es_allowin = 1'b1;
    fs_to_ds_valid = 1'b1; if_id_bus_in = ent(32'h50);
    cyc();
    fs_to_ds_valid = 1'b0; #1;
    chk("fl_next", id_bus_out, ent(32'h50));
    cyc();
    chk("fl_drain", 64'(q_empty), 64'd1);

    // stall holds head while pushes continue
    es_allowin = 1'b0;
    fs_to_ds_valid = 1'b1;
    if_id_bus_in = ent(32'h60); cyc();
    if_id_bus_in = ent(32'h64); cyc();
    stall_flag = 1'b1; es_allowin = 1'b1;
    if_id_bus_in = ent(32'h68); #1;
    chk("st0_bus", id_bus_out, ent(32'h60));
    chk("st0_vld", 64'(ds_to_es_valid), 64'd0);
    chk("st0_cnt", 64'(q_count), 64'd2);
    cyc();
    if_id_bus_in = ent(32'h6C); #1;
    chk("st1_cnt", 64'(q_count), 64'd3);
    chk("st1_bus", id_bus_out, ent(32'h60));
    cyc();
    if_id_bus_in = ent(32'h70); #1;
    chk("st2_cnt", 64'(q_count), 64'd4);
    chk("st2_alw", 64'(ds_allowin), 64'd0);
    chk("st2_bus", id_bus_out, ent(32'h60));
    cyc();
    chk("st3_cnt", 64'(q_count), 64'd4);
    stall_flag = 1'b0; #1;
    chk("st4_vld", 64'(ds_to_es_valid), 64'd1);
    chk("st4_alw", 64'(ds_allowin), 64'd1);
    chk("st4_bus", id_bus_out, ent(32'h60));
    cyc();
    fs_to_ds_valid = 1'b0; #1;
    chk("st5_bus", id_bus_out, ent(32'h64));
    chk("st5_cnt", 64'(q_count), 64'd4);
    cyc();
    es_allowin = 1'b0; #1;
    chk("st6_bus", id_bus_out, ent(32'h68));
    chk("st6_cnt", 64'(q_count), 64'd3);

    // asynchronous reset mid-cycle with 3 entries
    #2 rst_n = 1'b0; #1;
    chk("ar_cnt", 64'(q_count), 64'd0);
    chk("ar_vld", 64'(ds_to_es_valid), 64'd0);
    chk("ar_alw", 64'(ds_allowin), 64'd1);
    chk("ar_bus", id_bus_out, NOP0);
`ifdef ID_QUEUE_PERF_EN
    chk("ar_pfl", 64'(perf_flush_cnt), 64'd0);
    chk("ar_pst", 64'(perf_stall_cnt), 64'd0);
`endif
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
